// File: rtl/frame_bit_sequencer.sv
// Frame sequencer for one NeoPixel channel. It reads pixel words from the pixel RAM and
// shifts them MSB-first into the bit waveform generator, then holds the latch gap and pulses done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for frame_start_i; config latched on accept
// S_FETCH | read strobe for pixel 0 on the RAM port
// S_LOAD  | pixel 0 captured into the shift register
// S_SEND  | bits streamed to the generator; next pixel prefetched
// S_GAP   | line idle for the latched gap (down-counter)
// S_DONE  | one-cycle done pulse, busy still high
module frame_bit_sequencer #(
  parameter int PIXEL_BITS = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  frame_start_i,
  input  logic [ADDR_WIDTH:0]   pixel_num_i,
  input  logic [GAP_WIDTH-1:0]  gap_time_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [PIXEL_BITS-1:0] rd_data_i,
  output logic                  bit_vld_o,
  output logic                  bit_data_o,
  input  logic                  bit_rdy_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BW = $clog2(PIXEL_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   pix_left_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;
  logic [PIXEL_BITS-1:0] shift_q;
  logic [PIXEL_BITS-1:0] buf_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  cap_q;
  logic                  adv;
  logic                  last_bit;
  logic                  last_pix;

  assign adv        = (state_q == S_SEND) && bit_vld_o && bit_rdy_i;
  assign last_bit   = (bit_cnt_q == '0);
  assign last_pix   = (pix_left_q == (ADDR_WIDTH+1)'(1));
  // Shifting zeros in means the line reads 0 once the final bit has gone.
  assign bit_data_o = shift_q[PIXEL_BITS-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          if (pixel_num_i == '0) begin
            state_d = (gap_time_i == '0) ? S_DONE : S_GAP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        if (adv && last_bit && last_pix) begin
          state_d = (gap_q == '0) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_WIDTH'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_en_o    <= 1'b0;
      rd_addr_o  <= '0;
      bit_vld_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pix_left_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      bit_cnt_q  <= '0;
      cap_q      <= 1'b0;
    end else begin
      rd_en_o <= 1'b0;
      cap_q   <= rd_en_o;
      busy_o  <= (state_d != S_IDLE);
      done_o  <= (state_d == S_DONE);
      if (cap_q) buf_q <= rd_data_i;

      case (state_q)
        S_IDLE: begin
          if (frame_start_i) begin
            pix_left_q <= pixel_num_i;
            gap_q      <= gap_time_i;
            gap_cnt_q  <= gap_time_i;
            rd_addr_o  <= '0;
            rd_en_o    <= (pixel_num_i != '0);
          end
        end
        S_LOAD: begin
          shift_q   <= rd_data_i;
          bit_cnt_q <= BW'(PIXEL_BITS-1);
          bit_vld_o <= 1'b1;
          if (!last_pix) begin
            rd_en_o   <= 1'b1;
            rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
          end
        end
        S_SEND: begin
          if (adv) begin
            if (last_bit) begin
              bit_cnt_q  <= BW'(PIXEL_BITS-1);
              pix_left_q <= pix_left_q - (ADDR_WIDTH+1)'(1);
              if (last_pix) begin
                bit_vld_o <= 1'b0;
                shift_q   <= '0;
                gap_cnt_q <= gap_q;
              end else begin
                shift_q <= buf_q;
                // Prefetch the pixel after the one just loaded, if there is one.
                if (pix_left_q > (ADDR_WIDTH+1)'(2)) begin
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
                end
              end
            end else begin
              shift_q   <= shift_q << 1;
              bit_cnt_q <= bit_cnt_q - BW'(1);
            end
          end
        end
        S_GAP: gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule
